// File: rtl/axi_lite_aw_slave_if.sv
// rtl/axi_lite_aw_slave_if.sv - AXI-lite write-address channel plus local consumer port bundle
interface axi_lite_aw_slave_if #(
    parameter int DEPTH = 4
);
    logic [31:0]              AWADDR;
    logic                     AWVALID;
    logic                     AWREADY;
    logic [31:0]              addr_out;
    logic                     addr_err;
    logic                     addr_valid;
    logic                     addr_ready;
    logic [$clog2(DEPTH):0]   level;
    logic [7:0]               err_cnt;

    modport slave (
        input  AWADDR, AWVALID, addr_ready,
        output AWREADY, addr_out, addr_err, addr_valid, level, err_cnt
    );

    modport master (
        output AWADDR, AWVALID, addr_ready,
        input  AWREADY, addr_out, addr_err, addr_valid, level, err_cnt
    );
endinterface

// File: rtl/axi_lite_aw_slave.sv
// rtl/axi_lite_aw_slave.sv - AXI-lite AW slave with region decode and fall-through address buffer
module axi_lite_aw_slave #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000
) (
    input  logic                 clk,
    input  logic                 reset,
    axi_lite_aw_slave_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          awready_q, awready_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic push, pop, err_in;

    assign err_in = ((bus.AWADDR & ADDR_MASK) != (BASE_ADDR & ADDR_MASK));
    assign push   = bus.AWVALID && awready_q;
    // Popping an empty buffer is impossible because addr_valid gates the pop.
    assign pop    = (level_q != '0) && bus.addr_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_cnt_d = err_cnt_q;
        level_d   = level_q + LW'(push) - LW'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (err_in && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Ready looks only at the post-edge level, so a full buffer never bypasses.
        awready_d = (level_d < LW'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            awready_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            awready_q <= awready_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {err_in, bus.AWADDR};
        end
    end

    assign {bus.addr_err, bus.addr_out} = mem_q[rd_ptr_q];
    assign bus.addr_valid = (level_q != '0);
    assign bus.AWREADY    = awready_q;
    assign bus.level      = level_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_axi_lite_aw_slave.sv
// tb/tb_axi_lite_aw_slave.sv - scoreboard bench for axi_lite_aw_slave
module tb_axi_lite_aw_slave;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] MASK  = 32'hFFFF_F000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_lite_aw_slave_if #(.DEPTH(DEPTH)) bus ();

    axi_lite_aw_slave #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE), .ADDR_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [32:0] exp_q[$];
    int          model_err;
    int          total;
    int          bad;
    bit          mon_en;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return (a & MASK) != (BASE & MASK);
    endfunction

    function automatic logic [31:0] gen_addr(input int mode);
        logic [31:0] r;
        r = $urandom;
        case (mode)
            1:       return 32'h0000_2000;
            2:       return {20'h0, r[11:0]};
            3:       return 32'h0000_0010;
            default: return ($urandom_range(0, 2) == 0) ? r : {20'h0, r[11:0]};
        endcase
    endfunction

    // pv/pr: percent chance of offering a new address / asserting addr_ready.
    task automatic run_cycles(input int n, input int pv, input int pr, input int mode);
        logic        acc;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!bus.AWVALID) begin
                if ($urandom_range(0, 99) < pv) begin
                    bus.AWVALID = 1'b1;
                    bus.AWADDR  = gen_addr(mode);
                end else begin
                    bus.AWADDR  = $urandom;
                end
            end
            bus.addr_ready = ($urandom_range(0, 99) < pr);
            #1;
            acc = bus.AWVALID && bus.AWREADY;
            a   = bus.AWADDR;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back({is_err(a), a});
                if (is_err(a)) model_err++;
                #1 bus.AWVALID = 1'b0;
            end
        end
    endtask

    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("level", bus.level, exp_q.size());
                chk("addr_valid", bus.addr_valid, exp_q.size() != 0);
                chk("awready", bus.AWREADY, exp_q.size() < DEPTH);
                chk("err_cnt", bus.err_cnt, (model_err > 255) ? 255 : model_err);
                if (bus.addr_valid && bus.addr_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_entry", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("addr_out", bus.addr_out, e[31:0]);
                        chk("addr_err", bus.addr_err, e[32]);
                    end
                end
            end
        end
    end

    initial begin
        total = 0; bad = 0; model_err = 0; mon_en = 1'b0;
        bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.addr_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_awready", bus.AWREADY, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_addr_valid", bus.addr_valid, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        reset = 1'b0;
        #1 chk("awready_before_edge", bus.AWREADY, 0);
        @(posedge clk);
        #1;
        chk("awready_after_release", bus.AWREADY, 1);
        chk("level_after_release", bus.level, 0);
        mon_en = 1'b1;

        run_cycles(1, 100, 100, 3);
        #1 chk("single_valid", bus.addr_valid, 1);
        run_cycles(4, 0, 100, 0);

        run_cycles(8, 100, 0, 2);
        chk("full_level", bus.level, DEPTH);
        chk("full_awready", bus.AWREADY, 0);
        chk("fifth_held", bus.AWVALID, 1);
        run_cycles(1, 100, 100, 2);
        run_cycles(2, 0, 0, 2);
        chk("refill_level", bus.level, DEPTH);
        run_cycles(8, 0, 100, 0);

        run_cycles(2, 100, 0, 2);
        chk("level_two", bus.level, 2);
        run_cycles(12, 100, 100, 2);
        chk("level_two_steady", bus.level, 2);
        run_cycles(8, 0, 100, 0);

        run_cycles(1, 100, 100, 1);
        chk("err_cnt_one", bus.err_cnt, 1);
        run_cycles(320, 100, 100, 1);
        chk("err_cnt_sat", bus.err_cnt, 8'hFF);
        run_cycles(6, 0, 100, 0);

        run_cycles(600, 60, 50, 0);
        run_cycles(10, 0, 100, 0);

        run_cycles(3, 100, 0, 2);
        @(negedge clk);
        mon_en = 1'b0;
        bus.AWVALID = 1'b0;
        bus.addr_ready = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("midrst_addr_valid", bus.addr_valid, 0);
        chk("midrst_awready", bus.AWREADY, 0);
        chk("midrst_level", bus.level, 0);
        chk("midrst_err_cnt", bus.err_cnt, 0);
        exp_q.delete();
        model_err = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("awready_after_midrst", bus.AWREADY, 1);
        mon_en = 1'b1;
        run_cycles(200, 70, 60, 0);
        run_cycles(10, 0, 100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_aw_slave.md
AXI_LITE_AW_SLAVE -- requirements
Module: axi_lite_aw_slave

Interface
REQ-001 Parameter DEPTH, default 4, address buffer entries; the block SHALL support any power of two >= 2.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, base of the decoded region.
REQ-003 Parameter ADDR_MASK, default 32'hFFFF_F000, selects the AWADDR bits compared against BASE_ADDR.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 AWADDR  input  32  write address from the AXI-lite master.
REQ-007 AWVALID  input  1  master address valid.
REQ-008 AWREADY  output  1  slave address ready; registered.
REQ-009 addr_out  output  32  head-of-buffer address to the local consumer.
REQ-010 addr_err  output  1  head-of-buffer decode error flag, qualified by addr_valid.
REQ-011 addr_valid  output  1  buffer non-empty.
REQ-012 addr_ready  input  1  consumer accepts the head entry.
REQ-013 level  output  $clog2(DEPTH)+1  current entry count.
REQ-014 err_cnt  output  8  count of accepted out-of-region addresses.

Function
REQ-015 Accept occurs on a clock edge where AWVALID && AWREADY; only accepts SHALL push an entry.
REQ-016 A pushed entry SHALL store {err, AWADDR}, with err = ((AWADDR & ADDR_MASK) != (BASE_ADDR & ADDR_MASK)).
REQ-017 Pop occurs on a clock edge where addr_valid && addr_ready; the head entry SHALL be removed.
REQ-018 addr_valid SHALL equal (level != 0).
REQ-019 addr_out/addr_err SHALL present the head entry combinationally from storage (first-word fall-through): one-cycle latency from the accept edge to addr_valid high.
REQ-020 addr_out/addr_err SHALL hold stable while addr_valid && !addr_ready.
REQ-021 AWREADY SHALL be registered: next AWREADY = (level_next < DEPTH), where level_next is level after this edge's push/pop.
REQ-022 Full (level == DEPTH): AWREADY low; a pop SHALL raise AWREADY on the following edge; no same-cycle bypass of a full buffer.
REQ-023 Simultaneous push and pop with level > 0: both SHALL occur and level SHALL be unchanged.
REQ-024 Empty buffer: addr_ready SHALL be ignored; there SHALL be no pop and no underflow.
REQ-025 Read/write pointers are $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-026 Entries SHALL be delivered in accept order with no loss or duplication.
REQ-027 err_cnt SHALL increment on each accepted address with err = 1 and saturate at 8'hFF.
REQ-028 The block SHALL ignore AWADDR when AWVALID is low and SHALL never drop a handshake the master has observed.

Reset
REQ-029 While reset is high: AWREADY = 0, level = 0, addr_valid = 0, err_cnt = 0, pointers = 0; addr_out/addr_err are don't-care.
REQ-030 Reset SHALL take effect asynchronously and discard all buffered entries, including a reset asserted mid-transfer.
REQ-031 AWREADY SHALL rise on the first rising clk edge after reset deasserts.

Verification
REQ-032 Reset release, AWVALID = 0 -> AWREADY = 1 after one edge; level = 0; addr_valid = 0.
REQ-033 Accept AWADDR = 32'h0000_0010, addr_ready = 1 -> addr_valid high one cycle after accept, addr_out = 32'h10, addr_err = 0, then level returns to 0.
REQ-034 addr_ready = 0; push 5 addresses back-to-back (DEPTH = 4) -> first 4 accepted, AWREADY low after the 4th; the 5th is held with AWVALID high; one pop -> AWREADY high on the next edge, 5th accepted, output order preserved.
REQ-035 Accept AWADDR = 32'h0000_2000 (defaults) -> addr_err = 1 at head, err_cnt = 1; 300 such accepts -> err_cnt = 8'hFF.
REQ-036 level = 2, push and pop on the same edge -> level stays 2; continuous traffic across 10 entries shows correct pointer wrap and order.
REQ-037 Reset asserted with level = 3 mid-stream -> addr_valid = 0, AWREADY = 0 immediately; after release, no stale entries appear.
